// File: rtl/sdrc_req_split.sv
// Request splitter / bank router: breaks one application burst into
// page-contained chunks and hands them to the bank FSMs over r2b/b2r.
module sdrc_req_split #(
   parameter int APP_AW = 26,
   parameter int REQ_BW = 8,
   parameter int ID_W   = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        cfg_colbits,
   input  logic              app_req,
   input  logic [APP_AW-1:0] app_req_addr,
   input  logic [REQ_BW-1:0] app_req_len,
   input  logic              app_req_wr_n,
   input  logic              app_req_wrap,
   input  logic [ID_W-1:0]   app_req_id,
   input  logic              app_dma_last,
   output logic              app_req_ack,
   output logic              r2b_req,
   output logic [1:0]        r2b_ba,
   output logic [12:0]       r2b_raddr,
   output logic [12:0]       r2b_caddr,
   output logic [REQ_BW-1:0] r2b_len,
   output logic              r2b_write,
   output logic              r2b_start,
   output logic              r2b_last,
   output logic              r2b_wrap,
   output logic [ID_W-1:0]   r2b_req_id,
   output logic              r2b_dma_last,
   input  logic              b2r_ack
);

   typedef enum logic {IDLE, XFR} state_t;
   localparam int LW = (REQ_BW > 12) ? REQ_BW : 12;

   state_t              state_q, state_d;
   logic [APP_AW-1:0]   addr_q, addr_d;
   logic [REQ_BW-1:0]   rem_q, rem_d;
   logic                wr_n_q, wr_n_d;
   logic                wrap_q, wrap_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic                dma_q, dma_d;
   logic [1:0]          colbits_q, colbits_d;
   logic                first_q, first_d;

   logic [3:0]          c;
   logic [APP_AW-1:0]   col;
   logic [1:0]          bank;
   logic [12:0]         row;
   logic [11:0]         page_rem;
   logic [REQ_BW-1:0]   chunk;
   logic                last;
   logic                xfr;

   // Address decode works off the column width latched at acceptance.
   always_comb begin
      c        = 4'd8 + {2'b00, colbits_q};
      col      = addr_q & ((APP_AW'(1) << c) - APP_AW'(1));
      bank     = 2'(addr_q >> c);
      row      = 13'(addr_q >> (c + 4'd2));
      page_rem = (12'd1 << c) - col[11:0];
      if (wrap_q || (LW'(rem_q) <= LW'(page_rem)))
         chunk = rem_q;
      else
         chunk = REQ_BW'(page_rem);
      last = (chunk == rem_q);
      xfr  = (state_q == XFR);
   end

   always_comb begin
      app_req_ack  = (state_q == IDLE) && app_req;
      r2b_req      = xfr;
      r2b_ba       = xfr ? bank : 2'd0;
      r2b_raddr    = xfr ? row : 13'd0;
      r2b_caddr    = xfr ? 13'(col) : 13'd0;
      r2b_len      = xfr ? chunk : '0;
      r2b_write    = xfr && !wr_n_q;
      r2b_start    = xfr && first_q;
      r2b_last     = xfr && last;
      r2b_wrap     = xfr && wrap_q;
      r2b_req_id   = xfr ? id_q : '0;
      r2b_dma_last = xfr && last && dma_q;
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      wr_n_d    = wr_n_q;
      wrap_d    = wrap_q;
      id_d      = id_q;
      dma_d     = dma_q;
      colbits_d = colbits_q;
      first_d   = first_q;
      case (state_q)
         IDLE: begin
            if (app_req) begin
               addr_d    = app_req_addr;
               rem_d     = app_req_len;
               wr_n_d    = app_req_wr_n;
               wrap_d    = app_req_wrap;
               id_d      = app_req_id;
               dma_d     = app_dma_last;
               colbits_d = cfg_colbits;
               first_d   = 1'b1;
               // Zero-length bursts are acknowledged and dropped.
               if (app_req_len != '0) state_d = XFR;
            end
         end
         XFR: begin
            if (b2r_ack) begin
               addr_d  = addr_q + APP_AW'(chunk);
               rem_d   = rem_q - chunk;
               first_d = 1'b0;
               if (last) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         rem_q     <= '0;
         wr_n_q    <= 1'b0;
         wrap_q    <= 1'b0;
         id_q      <= '0;
         dma_q     <= 1'b0;
         colbits_q <= 2'd0;
         first_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         wr_n_q    <= wr_n_d;
         wrap_q    <= wrap_d;
         id_q      <= id_d;
         dma_q     <= dma_d;
         colbits_q <= colbits_d;
         first_q   <= first_d;
      end
   end

endmodule
